// File: rtl/serial_checking_sink_pkg.sv
// Shared definitions for the serial flit link receive side.
// Holds link-level constants, flit field helpers, the throttle LFSR
// definition and the sink FSM state type.
package serial_checking_sink_pkg;

  localparam int unsigned DEF_ADDR_SZ = 4;
  localparam int unsigned DIRECTIONS  = 5;

  // Line level while no frame is in flight, and the level that opens a frame.
  localparam logic LINK_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;

  // Throttle LFSR: x^8 + x^6 + x^5 + x^4 + 1, non-zero seed.
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Flit layout: {dest, src, seq}, dest in the top ADDR_SZ bits.
  function automatic int unsigned dest_hi(input int unsigned flit_sz);
    return flit_sz - 1;
  endfunction

  function automatic int unsigned src_hi(input int unsigned flit_sz,
                                         input int unsigned addr_sz);
    return flit_sz - addr_sz - 1;
  endfunction

  function automatic int unsigned seq_w(input int unsigned flit_sz,
                                        input int unsigned addr_sz);
    return flit_sz - 2 * addr_sz;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_PROC,
    ST_HOLD
  } sink_state_t;

endpackage

// File: rtl/serial_checking_sink_deser.sv
// Serial deserialiser: detects a start bit while armed, then collects
// FLIT_SZ data bits LSB first, one per clock.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   serial_in   - link data
//   armed       - a start bit is accepted only while high
//   frame_done  - high while the last data bit is on the line
//   near_done   - high while the second-to-last data bit is on the line
//   frame       - last completed flit, held until the next one completes
module serial_deser
  import serial_checking_sink_pkg::*;
#(
  parameter int unsigned FLIT_SZ = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               serial_in,
  input  logic               armed,
  output logic               frame_done,
  output logic               near_done,
  output logic [FLIT_SZ-1:0] frame
);

  localparam int unsigned CNT_W = $clog2(FLIT_SZ);

  logic               active;
  logic [CNT_W-1:0]   cnt;
  logic [FLIT_SZ-2:0] shift;

  assign frame_done = active && (cnt == CNT_W'(FLIT_SZ - 1));
  assign near_done  = active && (cnt == CNT_W'(FLIT_SZ - 2));

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
      shift  <= '0;
      frame  <= '0;
    end else if (!active) begin
      if (armed && serial_in == START_BIT) begin
        active <= 1'b1;
        cnt    <= '0;
      end
    end else begin
      // Right shift with new bits entering at the top: after FLIT_SZ-1 bits
      // the first-received bit sits at position 0.
      shift <= {serial_in, shift[FLIT_SZ-2:1]};
      cnt   <= cnt + 1'b1;
      if (frame_done) begin
        active <= 1'b0;
        frame  <= {serial_in, shift};
      end
    end
  end

endmodule

// File: rtl/serial_checking_sink.sv
// Receive end of the 1-bit serial flit link. Deserialises flits, checks the
// destination against this node's id and per-source sequence continuity,
// counts flits and errors, and applies backpressure (with LFSR throttling).
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   serial_in     - link data from the transmitter
//   channel_busy  - registered backpressure; no new frame may start while high
//   flit_valid    - one-cycle pulse per completed flit
//   flit_data     - last received flit
//   flit_count    - saturating count of received flits
//   error_count   - saturating count of flit errors and protocol violations
//   dest_err      - destination mismatch, coincident with flit_valid
//   seq_err       - sequence mismatch, coincident with flit_valid
module serial_checking_sink
  import serial_checking_sink_pkg::*;
#(
  parameter int unsigned id          = 0,
  parameter int unsigned FLIT_SZ     = 16,
  parameter int unsigned ADDR_SZ     = DEF_ADDR_SZ,
  parameter int unsigned hospitality = 255,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned PROC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               serial_in,
  output logic               channel_busy,
  output logic               flit_valid,
  output logic [FLIT_SZ-1:0] flit_data,
  output logic [19:0]        flit_count,
  output logic [15:0]        error_count,
  output logic               dest_err,
  output logic               seq_err
);

  localparam int unsigned SEQ_W     = seq_w(FLIT_SZ, ADDR_SZ);
  localparam int unsigned DEST_HI   = dest_hi(FLIT_SZ);
  localparam int unsigned SRC_HI    = src_hi(FLIT_SZ, ADDR_SZ);
  localparam int unsigned N_SRC     = 1 << ADDR_SZ;
  localparam int unsigned DWELL_MAX = (PROC_CYCLES > HOLD_CYCLES) ? PROC_CYCLES : HOLD_CYCLES;
  localparam int unsigned DWELL_W   = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
  localparam logic [ADDR_SZ-1:0] NODE_ID = ADDR_SZ'(id);
  localparam logic [7:0]         HOSP    = 8'(hospitality);

  sink_state_t        state, state_d;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         lfsr, lfsr_stepped;
  logic               frame_done, near_done, busy_d, violation;
  logic [FLIT_SZ-1:0] frame;
  logic [ADDR_SZ-1:0] dest, src;
  logic [SEQ_W-1:0]   seq;
  logic [SEQ_W-1:0]   exp_seq [N_SRC];
  logic [1:0]         err_inc;
  logic [16:0]        err_sum;

  serial_deser #(.FLIT_SZ(FLIT_SZ)) u_deser (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .armed      (state == ST_IDLE),
    .frame_done (frame_done),
    .near_done  (near_done),
    .frame      (frame)
  );

  assign flit_data    = frame;
  assign dest         = frame[DEST_HI -: ADDR_SZ];
  assign src          = frame[SRC_HI -: ADDR_SZ];
  assign seq          = frame[SEQ_W-1:0];
  assign lfsr_stepped = lfsr_step(lfsr);

  // A start bit while busy outside reception is ignored but counted.
  assign violation = channel_busy && (state != ST_RECV) && (serial_in == START_BIT);
  assign err_inc   = {1'b0, dest_err | seq_err} + {1'b0, violation};
  assign err_sum   = {1'b0, error_count} + 17'(err_inc);

  always_comb begin
    state_d    = state;
    flit_valid = 1'b0;
    dest_err   = 1'b0;
    seq_err    = 1'b0;
    case (state)
      ST_IDLE:  if (serial_in == START_BIT) state_d = ST_RECV;
      ST_RECV:  if (frame_done) state_d = ST_CHECK;
      ST_CHECK: begin
        flit_valid = 1'b1;
        dest_err   = (dest != NODE_ID);
        seq_err    = (seq != exp_seq[src]);
        state_d    = ST_PROC;
      end
      ST_PROC:
        if (dwell == DWELL_W'(PROC_CYCLES - 1))
          state_d = (lfsr_stepped > HOSP && HOLD_CYCLES != 0) ? ST_HOLD : ST_IDLE;
      ST_HOLD:
        if (dwell == DWELL_W'(HOLD_CYCLES - 1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Busy is registered, so it is derived from the next state; raising it
    // one bit early makes it visible during the final data bit.
    busy_d = (state_d inside {ST_CHECK, ST_PROC, ST_HOLD}) ||
             (state == ST_RECV && near_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      dwell        <= '0;
      lfsr         <= LFSR_SEED;
      channel_busy <= 1'b0;
      flit_count   <= '0;
      error_count  <= '0;
      for (int unsigned i = 0; i < N_SRC; i++) exp_seq[i] <= '0;
    end else begin
      state        <= state_d;
      channel_busy <= busy_d;
      if (state_d != state) dwell <= '0;
      else if (state inside {ST_PROC, ST_HOLD}) dwell <= dwell + 1'b1;
      if (state == ST_PROC && state_d != ST_PROC) lfsr <= lfsr_stepped;
      if (state == ST_CHECK) begin
        exp_seq[src] <= seq + 1'b1;
        if (flit_count != '1) flit_count <= flit_count + 1'b1;
      end
      error_count <= err_sum[16] ? '1 : err_sum[15:0];
    end
  end

endmodule
